dp_instr_sequencer: RTL

//  Multi-cycle controller that accepts 32-bit RV ALU instructions over a valid/ready handshake,

---
 rtl/dp_ctrl_pkg.sv | 39 +++
 rtl/dp_instr_sequencer_if.sv | 37 +++
 rtl/dp_instr_decoder.sv | 51 +++++
 rtl/dp_instr_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the instruction sequencer slice.
//   - ALU operation codes driven on alu_control
//   - RV32 opcode / funct7 constants for the supported instructions
//   - FSM state enum (also exported on the sequencer debug port)
//   - dec_t: decoded view of one instruction word
package dp_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu;
    logic       we;         // instruction writes rd
    logic       is_branch;
    logic       is_bne;     // branch sense: 0 = BEQ, 1 = BNE
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/dp_instr_sequencer_if.sv
// Bundle between the instruction source / datapath and the sequencer.
//   master : instruction source + datapath side (drives instr_valid, instr, zero_flag)
//   slave  : sequencer side (drives ready, register numbers, alu_control, strobes, counter)
//
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid && instr_ready are both high. instr_ready is high only while
// the sequencer is idle; instr and instr_valid are ignored at every other
// time, and the source may drop instr_valid at any point without penalty.
interface dp_instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             zero_flag;
  logic [4:0]       read_reg_num1;
  logic [4:0]       read_reg_num2;
  logic [4:0]       write_reg;
  logic [3:0]       alu_control;
  logic             regwrite;
  logic             done;
  logic             illegal;
  logic             branch_taken;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output instr_valid, instr, zero_flag,
    input  instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
           regwrite, done, illegal, branch_taken, retired_cnt
  );

  modport slave (
    input  instr_valid, instr, zero_flag,
    output instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
           regwrite, done, illegal, branch_taken, retired_cnt
  );
endinterface

// File: rtl/dp_instr_decoder.sv
// Combinational decoder: RV32 instruction word -> dec_t.
//   instr : instruction word
//   dec   : register numbers, ALU code, write-enable, branch flags, illegal
// Build option: DP_BRANCH_EN makes BEQ/BNE legal (compare via SUB, no write).
// Without it every branch opcode decodes as illegal.
module dp_instr_decoder
  import dp_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.alu     = ALU_AND;
    dec.illegal = 1'b1;
    if (opcode == OP_RTYPE) begin
      case ({funct7, funct3})
        {F7_BASE, 3'b000}: begin dec.alu = ALU_ADD; dec.we = 1'b1; dec.illegal = 1'b0; end
        {F7_ALT,  3'b000}: begin dec.alu = ALU_SUB; dec.we = 1'b1; dec.illegal = 1'b0; end
        {F7_BASE, 3'b111}: begin dec.alu = ALU_AND; dec.we = 1'b1; dec.illegal = 1'b0; end
        {F7_BASE, 3'b110}: begin dec.alu = ALU_OR;  dec.we = 1'b1; dec.illegal = 1'b0; end
        {F7_BASE, 3'b100}: begin dec.alu = ALU_XOR; dec.we = 1'b1; dec.illegal = 1'b0; end
        {F7_BASE, 3'b010}: begin dec.alu = ALU_SLT; dec.we = 1'b1; dec.illegal = 1'b0; end
        default: ;
      endcase
    end
`ifdef DP_BRANCH_EN
    else if (opcode == OP_BRANCH && (funct3 == 3'b000 || funct3 == 3'b001)) begin
      // The rd field of a branch carries immediate bits, so no register is named.
      dec.rd        = '0;
      dec.alu       = ALU_SUB;
      dec.is_branch = 1'b1;
      dec.is_bne    = funct3[0];
      dec.illegal   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Multi-cycle controller for a register-file + ALU datapath.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : dp_instr_sequencer_if.slave (handshake, datapath controls,
//                  done/illegal/branch_taken response, retired_cnt)
//   state_dbg    : current FSM state
// Parameter CNT_W: width of the wrapping retired-instruction counter.
// Build option DP_BRANCH_EN: BEQ/BNE supported, branch_taken reported with done;
// otherwise branch_taken is constant 0.
//
// Sequence per instruction: IDLE -(accept)-> DECODE -> EXEC -> RESP -> IDLE.
// Every output is a register loaded from the value the next state calls for,
// so each output changes on the same edge as the state it belongs to.
module dp_instr_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  dp_instr_sequencer_if.slave  bus,
  output state_t               state_dbg
);

  state_t state_q, state_d;
  dec_t   dec_w;
  logic   accept;

  // Attributes of the accepted instruction needed after the accept edge.
  logic write_q, illegal_q;

  logic             ready_q, ready_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]       alu_q, alu_d;
  logic             regwrite_q, regwrite_d;
  logic             done_q, done_d;
  logic             illegal_o_q, illegal_o_d;
  logic             branch_q, branch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dp_instr_decoder u_decoder (
    .instr (bus.instr),
    .dec   (dec_w)
  );

  // ready_q is high exactly in IDLE, so this is valid && ready.
  assign accept = (state_q == ST_IDLE) && bus.instr_valid;

`ifdef DP_BRANCH_EN
  logic is_branch_q, is_bne_q;
`else
  logic unused_branch;
  assign unused_branch = ^{dec_w.is_branch, dec_w.is_bne, bus.zero_flag};
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic (values loaded into the output registers)
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d  = rd_q;
    alu_d = alu_q;
    if (accept) begin
      rs1_d = dec_w.rs1;
      rs2_d = dec_w.rs2;
      rd_d  = dec_w.rd;
      alu_d = dec_w.alu;
    end
    ready_d     = (state_d == ST_IDLE);
    regwrite_d  = (state_d == ST_EXEC) && write_q;
    done_d      = (state_d == ST_RESP);
    illegal_o_d = done_d && illegal_q;
`ifdef DP_BRANCH_EN
    // zero_flag is taken at the EXEC->RESP edge, i.e. at the end of EXEC.
    branch_d    = done_d && is_branch_q && (bus.zero_flag ^ is_bne_q);
`else
    branch_d    = 1'b0;
`endif
    cnt_d = cnt_q;
    if (done_d && !illegal_q) cnt_d = cnt_q + 1'b1;
  end

  // Per-instruction attributes, captured on the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DP_BRANCH_EN
      is_branch_q <= 1'b0;
      is_bne_q    <= 1'b0;
`endif
    end else if (accept) begin
      // Writes to x0 are dropped here so regwrite never names x0.
      write_q   <= dec_w.we && (dec_w.rd != 5'd0);
      illegal_q <= dec_w.illegal;
`ifdef DP_BRANCH_EN
      is_branch_q <= dec_w.is_branch;
      is_bne_q    <= dec_w.is_bne;
`endif
    end
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      regwrite_q  <= 1'b0;
      done_q      <= 1'b0;
      illegal_o_q <= 1'b0;
      branch_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      regwrite_q  <= regwrite_d;
      done_q      <= done_d;
      illegal_o_q <= illegal_o_d;
      branch_q    <= branch_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.instr_ready   = ready_q;
  assign bus.read_reg_num1 = rs1_q;
  assign bus.read_reg_num2 = rs2_q;
  assign bus.write_reg     = rd_q;
  assign bus.alu_control   = alu_q;
  assign bus.regwrite      = regwrite_q;
  assign bus.done          = done_q;
  assign bus.illegal       = illegal_o_q;
  assign bus.branch_taken  = branch_q;
  assign bus.retired_cnt   = cnt_q;
  assign state_dbg         = state_q;

endmodule
